imem_loader: RTL and testbench

- Boot-time writer for the single-cycle processor's instruction memory.
- Accepts a byte stream through a valid/ready handshake, assembles 32-bit little-endian instruction words and writes them to consecutive IMEM addresses.
- Holds the processor in reset via CORE_RST until the load completes, then releases it.
- Sits between the host/UART byte source and the Single_Cycle_Processor's IMEM write port and reset input.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the IMEM boot loader.
// Imported by the loader top and by its word assembler.
package loader_pkg;

  localparam int HDR_W          = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR_LO = 3'd1;
  localparam state_t ST_HDR_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_FLUSH  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the boot loader.
// The slave modport is the loader side; master is the host / memory side.
interface imem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic [7:0]        BYTE_IN;
  logic              BYTE_VALID;
  logic              BYTE_READY;
  logic              IMEM_WE;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [DATA_W-1:0] IMEM_WDATA;

  modport master (
    output BYTE_IN, BYTE_VALID,
    input  BYTE_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA
  );

  modport slave (
    input  BYTE_IN, BYTE_VALID,
    output BYTE_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into one instruction word.
// word is combinational so the completing byte is included in the same cycle.
module word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic              word_full,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-9:0] upper;

  // Bytes enter at the top and shift down, so the first byte ends up as the LSB.
  assign word      = {byte_in, upper};
  assign word_full = shift_en && (byte_idx == IDX_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      upper    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      upper    <= '0;
    end else if (shift_en) begin
      upper    <= word[DATA_W-1:8];
      byte_idx <= word_full ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: reads a 16-bit word count, then that many words,
// writing them to consecutive addresses while holding the core in reset.
import loader_pkg::*;

module imem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            ABORT,
  imem_loader_if.slave    bus,
  output logic            CORE_RST,
  output logic            DONE,
  output logic            ERR
);

  state_t            state;
  logic [HDR_W-1:0]  count;
  logic [ADDR_W-1:0] word_idx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              ready;
  logic              take;
  logic              loading;
  logic              abort_now;
  logic              start_now;
  logic              word_full;
  logic [DATA_W-1:0] word;
  logic [HDR_W-1:0]  hdr_count;
  logic              last_word;

  assign ready     = (state == ST_HDR_LO) || (state == ST_HDR_HI) || (state == ST_DATA);
  assign take      = bus.BYTE_VALID && ready;
  assign loading   = ready || (state == ST_FLUSH);
  assign abort_now = ABORT && loading;
  assign start_now = START && !loading;
  assign hdr_count = {bus.BYTE_IN, count[7:0]};
  assign last_word = (HDR_W'(word_idx) + HDR_W'(1)) == count;

  assign bus.BYTE_READY = ready;
  assign bus.IMEM_WE    = we_q;
  assign bus.IMEM_ADDR  = addr_q;
  assign bus.IMEM_WDATA = wdata_q;

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (abort_now || start_now),
    .shift_en  (take && (state == ST_DATA) && !abort_now),
    .byte_in   (bus.BYTE_IN),
    .word_full (word_full),
    .word      (word)
  );

  // ABORT wins over everything in a loading state; the write strobe is a one-cycle pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      count    <= '0;
      word_idx <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      CORE_RST <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (abort_now) begin
        state    <= ST_IDLE;
        CORE_RST <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (START) begin
              state    <= ST_HDR_LO;
              count    <= '0;
              word_idx <= '0;
              CORE_RST <= 1'b1;
              DONE     <= 1'b0;
              ERR      <= 1'b0;
            end
          end
          ST_HDR_LO: begin
            if (take) begin
              count[7:0] <= bus.BYTE_IN;
              state      <= ST_HDR_HI;
            end
          end
          ST_HDR_HI: begin
            if (take) begin
              count <= hdr_count;
              if (hdr_count == '0) begin
                state    <= ST_DONE;
                DONE     <= 1'b1;
                CORE_RST <= 1'b0;
              end else if (hdr_count > HDR_W'(DEPTH)) begin
                state <= ST_ERROR;
                ERR   <= 1'b1;
              end else begin
                state    <= ST_DATA;
                word_idx <= '0;
              end
            end
          end
          ST_DATA: begin
            if (word_full) begin
              we_q    <= 1'b1;
              addr_q  <= word_idx;
              wdata_q <= word;
              if (last_word) state <= ST_FLUSH;
              else           word_idx <= word_idx + 1'b1;
            end
          end
          ST_FLUSH: begin
            state    <= ST_DONE;
            DONE     <= 1'b1;
            CORE_RST <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; IMEM writes are logged
// on the falling edge and compared against hand-computed words.
module tb_imem_loader;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  logic CORE_RST, DONE, ERR;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0]  stream[$];
  logic [7:0]  wrAddr[0:63];
  logic [31:0] wrData[0:63];
  int          wrCount = 0;
  int          base;

  imem_loader_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  imem_loader #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .ABORT    (ABORT),
    .bus      (bus),
    .CORE_RST (CORE_RST),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.IMEM_WE === 1'b1 && wrCount < 64) begin
      wrAddr[wrCount] <= bus.IMEM_ADDR;
      wrData[wrCount] <= bus.IMEM_WDATA;
      wrCount         <= wrCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offer one byte from a falling edge and return on the falling edge after it is taken.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    bus.BYTE_IN    = b;
    bus.BYTE_VALID = 1'b1;
    while (bus.BYTE_READY !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (bus.BYTE_READY !== 1'b1) checkOutput("ready_timeout", 32'(bus.BYTE_READY), 32'd1);
    @(negedge CLK);
    bus.BYTE_VALID = 1'b0;
  endtask

  task automatic sendStream(input int maxBubble);
    for (int i = 0; i < stream.size(); i++) begin
      applyStimulus(stream[i]);
      if (maxBubble > 0 && i < stream.size() - 1)
        repeat ($urandom_range(maxBubble, 1)) @(negedge CLK);
    end
  endtask

  task automatic startPulse();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Called on the FLUSH cycle of the standard two-word load.
  task automatic checkTwoWordLoad(input string tag, input int first);
    checkOutput({tag, "_flush_we"}, 32'(bus.IMEM_WE), 32'd1);
    checkOutput({tag, "_flush_rdy"}, 32'(bus.BYTE_READY), 32'd0);
    checkOutput({tag, "_core_rst_hold"}, 32'(CORE_RST), 32'd1);
    @(negedge CLK);
    checkOutput({tag, "_done"}, 32'(DONE), 32'd1);
    checkOutput({tag, "_core_rst"}, 32'(CORE_RST), 32'd0);
    checkOutput({tag, "_we_off"}, 32'(bus.IMEM_WE), 32'd0);
    @(negedge CLK);
    checkOutput({tag, "_nwrites"}, 32'(wrCount - first), 32'd2);
    checkOutput({tag, "_addr0"}, 32'(wrAddr[first]), 32'd0);
    checkOutput({tag, "_data0"}, wrData[first], 32'h12345678);
    checkOutput({tag, "_addr1"}, 32'(wrAddr[first+1]), 32'd1);
    checkOutput({tag, "_data1"}, wrData[first+1], 32'hDEADBEEF);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.BYTE_IN    = 8'h00;
    bus.BYTE_VALID = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      START          = 1'($urandom);
      ABORT          = 1'($urandom);
      bus.BYTE_VALID = 1'($urandom);
      bus.BYTE_IN    = 8'($urandom);
      #1;
      checkOutput("rst_core_rst", 32'(CORE_RST), 32'd1);
      checkOutput("rst_ready", 32'(bus.BYTE_READY), 32'd0);
      checkOutput("rst_we", 32'(bus.IMEM_WE), 32'd0);
      checkOutput("rst_done", 32'(DONE), 32'd0);
      checkOutput("rst_err", 32'(ERR), 32'd0);
    end
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    bus.BYTE_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] byte offered in IDLE, then bubbly two-word load");
    bus.BYTE_IN    = 8'h55;
    bus.BYTE_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("idle_ready", 32'(bus.BYTE_READY), 32'd0);
    bus.BYTE_VALID = 1'b0;
    base = wrCount;
    startPulse();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendStream(3);
    checkTwoWordLoad("bubble", base);

    $display("[TB] restart from DONE, back-to-back two-word load");
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("restart_core_rst", 32'(CORE_RST), 32'd1);
    checkOutput("restart_done", 32'(DONE), 32'd0);
    base = wrCount;
    sendStream(0);
    checkTwoWordLoad("b2b", base);

    $display("[TB] zero-length header");
    base = wrCount;
    startPulse();
    stream = '{8'h00, 8'h00};
    sendStream(0);
    checkOutput("zero_done", 32'(DONE), 32'd1);
    checkOutput("zero_core_rst", 32'(CORE_RST), 32'd0);
    repeat (2) @(negedge CLK);
    checkOutput("zero_nwrites", 32'(wrCount - base), 32'd0);

    $display("[TB] oversize header 257");
    base = wrCount;
    startPulse();
    stream = '{8'h01, 8'h01};
    sendStream(0);
    checkOutput("over_err", 32'(ERR), 32'd1);
    checkOutput("over_core_rst", 32'(CORE_RST), 32'd1);
    checkOutput("over_ready", 32'(bus.BYTE_READY), 32'd0);
    checkOutput("over_done", 32'(DONE), 32'd0);
    repeat (2) @(negedge CLK);
    checkOutput("over_nwrites", 32'(wrCount - base), 32'd0);

    $display("[TB] abort after five data bytes");
    base = wrCount;
    startPulse();
    checkOutput("retry_err_clr", 32'(ERR), 32'd0);
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    sendStream(0);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checkOutput("abort_ready", 32'(bus.BYTE_READY), 32'd0);
    checkOutput("abort_core_rst", 32'(CORE_RST), 32'd1);
    checkOutput("abort_we", 32'(bus.IMEM_WE), 32'd0);
    checkOutput("abort_done", 32'(DONE), 32'd0);
    repeat (2) @(negedge CLK);
    checkOutput("abort_nwrites", 32'(wrCount - base), 32'd1);
    checkOutput("abort_addr0", 32'(wrAddr[base]), 32'd0);
    checkOutput("abort_data0", wrData[base], 32'h12345678);

    $display("[TB] reset asserted mid-load");
    startPulse();
    sendStream(0);
    RST = 1'b0;
    #1;
    checkOutput("midrst_core_rst", 32'(CORE_RST), 32'd1);
    checkOutput("midrst_ready", 32'(bus.BYTE_READY), 32'd0);
    checkOutput("midrst_we", 32'(bus.IMEM_WE), 32'd0);
    checkOutput("midrst_addr", 32'(bus.IMEM_ADDR), 32'd0);
    checkOutput("midrst_wdata", bus.IMEM_WDATA, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] full load after reset");
    base = wrCount;
    startPulse();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendStream(0);
    checkTwoWordLoad("postrst", base);

    $display("[TB] reload with one word");
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("reload_core_rst", 32'(CORE_RST), 32'd1);
    checkOutput("reload_done", 32'(DONE), 32'd0);
    base = wrCount;
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendStream(0);
    checkOutput("reload_we", 32'(bus.IMEM_WE), 32'd1);
    @(negedge CLK);
    checkOutput("reload_done_set", 32'(DONE), 32'd1);
    checkOutput("reload_core_run", 32'(CORE_RST), 32'd0);
    @(negedge CLK);
    checkOutput("reload_nwrites", 32'(wrCount - base), 32'd1);
    checkOutput("reload_addr", 32'(wrAddr[base]), 32'd0);
    checkOutput("reload_data", wrData[base], 32'hDDCCBBAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
